// File: rtl/wb_stream_reader_ctrl.sv
// Wishbone burst write engine: drains a first-word-fall-through FIFO into a
// circular memory buffer using incrementing bursts, pulsing irq on each wrap.
module wb_stream_reader_ctrl #(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 4,
    parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    input  logic                 wbm_rty_i,
    input  logic [WB_DW-1:0]     fifo_d,
    output logic                 fifo_rd,
    input  logic [FIFO_AW:0]     fifo_cnt,
    input  logic                 enable,
    input  logic [WB_AW-1:0]     start_adr,
    input  logic [WB_AW-1:0]     buf_size,
    input  logic [WB_AW-1:0]     burst_size,
    output logic                 irq,
    output logic                 bus_err,
    output logic                 busy
);

    localparam int               BW      = $clog2(MAX_BURST_LEN + 1);
    localparam logic [WB_AW-1:0] STRIDE  = WB_AW'(WB_DW / 8);
    localparam logic [WB_AW-1:0] MAX_LEN = WB_AW'(MAX_BURST_LEN);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WB_AW-1:0]   word_cnt_q, word_cnt_d;
    logic [WB_AW-1:0]   buf_size_q, buf_size_d;
    logic [BW-1:0]      beat_cnt_q, beat_cnt_d;
    logic [WB_AW-1:0]   adr_q, adr_d;
    logic [2:0]         cti_q, cti_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               irq_q, irq_d;
    logic               bus_err_q, bus_err_d;

    logic [WB_AW-1:0]   eff_s;
    logic [WB_AW-1:0]   start_idx_s;
    logic [WB_AW-1:0]   remain_s;
    logic [WB_AW-1:0]   len_s;
    logic [WB_AW-1:0]   word_inc_s;
    logic               ack_s;
    logic               unused_s;

    // Read data and retry carry no information for a write-only master;
    // retry is simply a wait because stb stays up until ack or err.
    assign unused_s = ^{wbm_dat_i, wbm_rty_i};

    assign ack_s     = wbm_ack_i & stb_q & (state_q == BURST);
    assign fifo_rd   = ack_s;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = fifo_d;
    assign wbm_sel_o = '1;
    assign wbm_we_o  = cyc_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_cti_o = cti_q;
    assign wbm_bte_o = 2'b00;
    assign irq       = irq_q;
    assign bus_err   = bus_err_q;
    assign busy      = cyc_q;

    // Length of the next burst: clamped request, limited by the words left
    // before the buffer wraps. A stale word count beyond a shrunken buffer
    // restarts at the base rather than running past the end.
    always_comb begin
        eff_s = burst_size;
        if (burst_size == '0) begin
            eff_s = WB_AW'(1);
        end else if (burst_size > MAX_LEN) begin
            eff_s = MAX_LEN;
        end else begin
            eff_s = burst_size;
        end
        if (word_cnt_q >= buf_size) begin
            start_idx_s = '0;
        end else begin
            start_idx_s = word_cnt_q;
        end
        remain_s = buf_size - start_idx_s;
        if (eff_s < remain_s) begin
            len_s = eff_s;
        end else begin
            len_s = remain_s;
        end
    end

    // Next-state and registered-output logic for the IDLE/BURST controller.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        buf_size_d = buf_size_q;
        beat_cnt_d = beat_cnt_q;
        adr_d      = adr_q;
        cti_d      = cti_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        irq_d      = 1'b0;
        bus_err_d  = bus_err_q;
        word_inc_s = word_cnt_q + WB_AW'(1);
        case (state_q)
            IDLE: begin
                cyc_d = 1'b0;
                stb_d = 1'b0;
                cti_d = 3'b000;
                if (!enable) begin
                    word_cnt_d = '0;
                    bus_err_d  = 1'b0;
                end else if (!bus_err_q && (buf_size != '0) &&
                             (WB_AW'(fifo_cnt) >= len_s)) begin
                    state_d    = BURST;
                    word_cnt_d = start_idx_s;
                    buf_size_d = buf_size;
                    beat_cnt_d = BW'(len_s);
                    adr_d      = start_adr + start_idx_s * STRIDE;
                    cyc_d      = 1'b1;
                    stb_d      = 1'b1;
                    cti_d      = (len_s == WB_AW'(1)) ? 3'b111 : 3'b010;
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (ack_s) begin
                    adr_d      = adr_q + STRIDE;
                    beat_cnt_d = beat_cnt_q - BW'(1);
                    if (beat_cnt_q == BW'(1)) begin
                        state_d = IDLE;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        cti_d   = 3'b000;
                        if (word_inc_s >= buf_size_q) begin
                            word_cnt_d = '0;
                            irq_d      = 1'b1;
                        end else begin
                            word_cnt_d = word_inc_s;
                        end
                    end else begin
                        word_cnt_d = word_inc_s;
                        cti_d      = (beat_cnt_q == BW'(2)) ? 3'b111 : 3'b010;
                    end
                end else if (wbm_err_i) begin
                    state_d   = IDLE;
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    cti_d     = 3'b000;
                    bus_err_d = 1'b1;
                end else begin
                    state_d = BURST;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                cti_d   = 3'b000;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            buf_size_q <= '0;
            beat_cnt_q <= '0;
            adr_q      <= '0;
            cti_q      <= 3'b000;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            irq_q      <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            buf_size_q <= buf_size_d;
            beat_cnt_q <= beat_cnt_d;
            adr_q      <= adr_d;
            cti_q      <= cti_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            irq_q      <= irq_d;
            bus_err_q  <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_wb_stream_reader_ctrl.sv
// Scoreboard bench: stimulus feeds words to a FIFO model and pushes the
// expected Wishbone beats; a negedge monitor compares every acknowledged beat.
module tb_wb_stream_reader_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
    logic [31:0] fifo_d;
    logic        fifo_rd;
    logic [4:0]  fifo_cnt;
    logic        enable;
    logic [31:0] start_adr, buf_size, burst_size;
    logic        irq, bus_err, busy;

    wb_stream_reader_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
        .fifo_d(fifo_d), .fifo_rd(fifo_rd), .fifo_cnt(fifo_cnt),
        .enable(enable), .start_adr(start_adr), .buf_size(buf_size),
        .burst_size(burst_size), .irq(irq), .bus_err(bus_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  cti;
        bit          irq;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] in_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_seen = 0;
    int          ack_total = 0;
    int          irq_cnt = 0;
    bit          pop_pending = 1'b0;
    bit          irq_due = 1'b0;

    // Slave controls
    bit          rand_mode = 1'b1;
    bit          zero_wait = 1'b0;
    int          ack_budget = 0;
    bit          err_req = 1'b0;

    // Reference model state: position in buffer and beats left in burst
    logic [31:0] m_start, m_buf, m_burst, m_wc;
    int          m_left = 0;

    // FIFO model: pop what the DUT took, refill from pending words (depth 16)
    always @(posedge clk) begin
        #1;
        if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
        while (in_q.size() > 0 && fifo_q.size() < 16) fifo_q.push_back(in_q.pop_front());
        fifo_d   = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
        fifo_cnt = 5'(fifo_q.size());
    end

    // Wishbone slave: random waits/retries, or a scripted ack count then err
    always @(posedge clk) begin
        #1;
        wbm_ack_i = 1'b0; wbm_rty_i = 1'b0; wbm_err_i = 1'b0;
        if (rst_n && wbm_cyc_o && wbm_stb_o) begin
            if (rand_mode) begin
                if (zero_wait || $urandom_range(2, 0) != 0) wbm_ack_i = 1'b1;
                else if ($urandom_range(1, 0) == 0) wbm_rty_i = 1'b1;
                if (wbm_ack_i && !zero_wait && $urandom_range(7, 0) == 0) wbm_err_i = 1'b1;
            end else if (ack_budget > 0) begin
                wbm_ack_i = 1'b1;
                ack_budget--;
            end else if (err_req) begin
                wbm_err_i = 1'b1;
                err_req = 1'b0;
            end
        end
    end

    // Monitor: compare each acknowledged beat and irq timing with expectations
    always @(negedge clk) begin
        if (!rst_n) begin
            pop_pending = 1'b0;
            irq_due     = 1'b0;
        end else begin
            pop_pending = fifo_rd;
            if (irq || irq_due) begin
                checks++;
                if (irq !== irq_due) begin
                    errors++;
                    $display("FAIL irq got=%b want=%b t=%0t", irq, irq_due, $time);
                end
                if (irq) irq_cnt++;
            end
            irq_due = 1'b0;
            if (wbm_cyc_o) begin
                cyc_seen++;
                checks++;
                if (wbm_we_o !== 1'b1 || busy !== 1'b1 || wbm_sel_o !== 4'hF || wbm_bte_o !== 2'b00 ||
                    fifo_rd !== (wbm_ack_i & wbm_stb_o)) begin
                    errors++;
                    $display("FAIL ctl we=%b busy=%b sel=%h bte=%b rd=%b ack=%b", wbm_we_o, busy,
                             wbm_sel_o, wbm_bte_o, fifo_rd, wbm_ack_i);
                end
            end
            if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
                beat_t e;
                ack_total++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat unexpected adr=%h dat=%h", wbm_adr_o, wbm_dat_o);
                end else begin
                    e = exp_q.pop_front();
                    irq_due = e.irq;
                    if (e.adr !== wbm_adr_o || e.dat !== wbm_dat_o || e.cti !== wbm_cti_o) begin
                        errors++;
                        $display("FAIL beat adr=%h want %h dat=%h want %h cti=%b want %b",
                                 wbm_adr_o, e.adr, wbm_dat_o, e.dat, wbm_cti_o, e.cti);
                    end
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Model: where does the next streamed word land, and with what cti/irq
    task automatic model_word(logic [31:0] d);
        beat_t       e;
        logic [31:0] eff;
        if (m_left == 0) begin
            eff    = (m_burst == 0) ? 32'd1 : ((m_burst > 32'd16) ? 32'd16 : m_burst);
            m_left = int'((eff < m_buf - m_wc) ? eff : (m_buf - m_wc));
        end
        e.adr = m_start + m_wc * 32'd4;
        e.dat = d;
        e.cti = (m_left == 1) ? 3'b111 : 3'b010;
        e.irq = 1'b0;
        m_left--;
        m_wc = m_wc + 32'd1;
        if (m_wc == m_buf) begin
            m_wc  = 32'd0;
            e.irq = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic push_word(logic [31:0] d);
        model_word(d);
        in_q.push_back(d);
    endtask

    task automatic top_up();
        while (m_left != 0) push_word($urandom);
    endtask

    task automatic model_reset();
        m_start = start_adr; m_buf = buf_size; m_burst = burst_size;
        m_wc = 32'd0; m_left = 0;
    endtask

    task automatic set_cfg(logic [31:0] sa, logic [31:0] bs, logic [31:0] bu);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        start_adr = sa; buf_size = bs; burst_size = bu;
        model_reset();
        enable = 1'b1;
    endtask

    task automatic drain(string tag);
        int n = 0;
        while ((exp_q.size() != 0 || in_q.size() != 0 || fifo_q.size() != 0 || wbm_cyc_o) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL drain_%s timeout exp_left=%0d want 0", tag, exp_q.size());
        end
    endtask

    task automatic wait_acks(int n);
        int base = ack_total;
        int t = 0;
        while (ack_total < base + n && t < 2000) begin @(negedge clk); t++; end
        chk("wait_acks", 32'(ack_total - base), 32'(n));
    endtask

    // Regenerate expectations for words still held in the FIFO model
    task automatic model_replay();
        model_reset();
        foreach (fifo_q[i]) model_word(fifo_q[i]);
        foreach (in_q[i]) model_word(in_q[i]);
    endtask

    initial begin
        int          base;
        int          n;
        logic [31:0] sa;
        rst_n = 1'b0; enable = 1'b0; wbm_dat_i = 32'h0;
        start_adr = 32'h0; buf_size = 32'h0; burst_size = 32'h0;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
        fifo_d = 32'h0; fifo_cnt = 5'd0;
        #3;
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_cti", 32'(wbm_cti_o), 32'd0);
        chk("rst_misc", {28'd0, fifo_rd, irq, bus_err, busy}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Basic zero-wait: two 4-beat bursts, one irq
        zero_wait = 1'b1;
        set_cfg(32'h1000, 32'd8, 32'd4);
        base = irq_cnt;
        for (int i = 0; i < 8; i++) push_word(32'hD000_0000 + 32'(i));
        drain("basic");
        chk("basic_irq", 32'(irq_cnt - base), 32'd1);

        // Tail clamp with waits: 4+2 per pass, two passes
        zero_wait = 1'b0;
        set_cfg(32'h1000, 32'd6, 32'd4);
        base = irq_cnt;
        for (int i = 0; i < 12; i++) push_word($urandom);
        drain("tail");
        chk("tail_irq", 32'(irq_cnt - base), 32'd2);

        // Insufficient data holds off the burst
        set_cfg(32'h1000, 32'd8, 32'd4);
        for (int i = 0; i < 3; i++) push_word($urandom);
        base = cyc_seen;
        repeat (10) @(negedge clk);
        chk("short_nocyc", 32'(cyc_seen - base), 32'd0);
        push_word($urandom);
        n = 0;
        while (!wbm_cyc_o && n < 4) begin @(negedge clk); n++; end
        chk("short_start", 32'(wbm_cyc_o), 32'd1);
        drain("short");

        // Randomised configurations, including clamps and address wrap
        for (int r = 0; r < 8; r++) begin
            sa = (r == 3) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            set_cfg(sa, 32'($urandom_range(20, 1)), 32'($urandom_range(20, 0)));
            n = $urandom_range(30, 1);
            for (int i = 0; i < n; i++) push_word($urandom);
            top_up();
            drain("rand");
        end

        // Bus error on beat 2 of a 4-beat burst
        set_cfg(32'h2000, 32'd16, 32'd4);
        rand_mode = 1'b0; ack_budget = 1; err_req = 1'b1;
        push_word(32'hE000_0000);
        for (int i = 1; i < 4; i++) in_q.push_back(32'hE000_0000 + 32'(i));
        n = 0;
        while (!bus_err && n < 200) begin @(negedge clk); n++; end
        chk("err_flag", 32'(bus_err), 32'd1);
        chk("err_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("err_left", 32'(fifo_q.size() + in_q.size()), 32'd3);
        base = cyc_seen;
        repeat (8) @(negedge clk);
        chk("err_hold", 32'(cyc_seen - base), 32'd0);
        chk("err_sticky", 32'(bus_err), 32'd1);
        rand_mode = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("err_clear", 32'(bus_err), 32'd0);
        model_replay();
        enable = 1'b1;
        top_up();
        drain("err");

        // Reset while the third beat waits for ack
        set_cfg(32'h3000, 32'd16, 32'd8);
        rand_mode = 1'b0; ack_budget = 2;
        for (int i = 0; i < 8; i++) push_word($urandom);
        wait_acks(2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_cycstb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        chk("mrst_out", {wbm_adr_o[27:0], fifo_rd, irq, bus_err, busy}, 32'd0);
        exp_q.delete();
        rand_mode = 1'b1;
        model_replay();
        @(negedge clk);
        rst_n = 1'b1;
        top_up();
        drain("mrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stream_reader_ctrl.md
Name: wb_stream_reader_ctrl

Overview:
- Wishbone master write engine: the mirror of the stream writer path.
- Drains a first-word-fall-through FIFO that the incoming stream fills, and writes its contents in incrementing Wishbone bursts into a circular memory buffer.
- Sits between the stream-side FIFO and system memory; configured by a register block (start address, buffer size, burst size, enable).
- Flags each completed buffer pass with a one-cycle interrupt pulse.

Parameters:
- WB_AW, 32, Wishbone address width (byte addresses).
- WB_DW, 32, Wishbone data width; word stride is WB_DW/8 bytes.
- FIFO_AW, 4, FIFO depth log2.
- MAX_BURST_LEN, 2**FIFO_AW, maximum beats per burst; burst_size is clamped to this.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- wbm_adr_o, out, WB_AW, burst beat byte address.
- wbm_dat_o, out, WB_DW, write data; wired directly to fifo_d.
- wbm_sel_o, out, WB_DW/8, all ones.
- wbm_we_o, out, 1, high whenever wbm_cyc_o is high.
- wbm_cyc_o, out, 1, bus cycle.
- wbm_stb_o, out, 1, strobe.
- wbm_cti_o, out, 3, 3'b010 incrementing, 3'b111 end-of-burst.
- wbm_bte_o, out, 2, always 2'b00 (linear).
- wbm_dat_i, in, WB_DW, unused.
- wbm_ack_i, in, 1, beat acknowledge.
- wbm_err_i, in, 1, bus error.
- wbm_rty_i, in, 1, retry.
- fifo_d, in, WB_DW, FIFO head word (FWFT).
- fifo_rd, out, 1, FIFO pop.
- fifo_cnt, in, FIFO_AW+1, FIFO fill level, 0..2**FIFO_AW.
- enable, in, 1, run enable.
- start_adr, in, WB_AW, buffer base byte address; word aligned.
- buf_size, in, WB_AW, buffer length in words.
- burst_size, in, WB_AW, requested beats per burst.
- irq, out, 1, one-cycle pulse on buffer wrap.
- bus_err, out, 1, sticky error flag.
- busy, out, 1, high while wbm_cyc_o is high.

Behaviour:
- Reset (async, rst_n=0) values:
  - State IDLE; word_cnt=0.
  - wbm_cyc_o=0, wbm_stb_o=0, wbm_cti_o=0, wbm_adr_o=0.
  - fifo_rd=0, irq=0, bus_err=0, busy=0.
- Reset mid-burst: drops cyc/stb immediately; no further pops.
- Effective burst length: eff = min(max(burst_size,1), MAX_BURST_LEN). len = min(eff, buf_size - word_cnt).
- FSM states: IDLE, BURST.
- IDLE:
  - While enable=0: word_cnt held at 0 and bus_err cleared.
  - If enable=1, bus_err=0, buf_size!=0 and fifo_cnt>=len: latch len into beat counter and go to BURST. cyc/stb assert on the next cycle.
  - buf_size=0 never starts.
- BURST:
  - cyc=stb=1; wbm_adr_o = start_adr + word_cnt*(WB_DW/8), computed modulo 2**WB_AW.
  - cti=3'b111 on the final beat (including single-beat bursts), else 3'b010.
- On ack:
  - fifo_rd=1 in the same cycle (combinational: ack & BURST & stb); word_cnt++; beat counter decrements.
  - Address advances for the next cycle.
  - Back-to-back acks pop one word per cycle.
- On last-beat ack:
  - Deassert cyc/stb next cycle; return to IDLE.
  - If word_cnt reaches buf_size: word_cnt wraps to 0 and irq pulses for exactly one cycle (the cycle after the last ack).
  - At least one idle cycle occurs between bursts.
- wbm_rty_i: treated as a wait; no pop, no advance, stb held.
- wbm_err_i, in BURST with no ack:
  - No pop; cyc/stb drop next cycle; go to IDLE.
  - bus_err=1, sticky until enable=0.
  - word_cnt keeps the failed beat's index; no irq.
- Simultaneous ack and err: ack wins.
- Enable deasserted mid-burst: burst completes normally, then the FSM idles and word_cnt clears.
- Config inputs are sampled only at burst start; changes mid-burst take effect from the next burst.
- fifo_cnt is never checked during a burst. The start condition guarantees len words are present; the upstream FIFO must not underflow.

Test Plan:
- Basic burst: buf_size=8, burst_size=4, start_adr=0x1000, FIFO preloaded with 8 words (D0..D7), zero-wait ack -> two bursts at 0x1000..0x100C and 0x1010..0x101C; cti 010,010,010,111 per burst; 8 pops; data in order; one irq pulse; word_cnt back to 0.
- Tail clamp: buf_size=6, burst_size=4, 6 words -> bursts of 4 then 2 (second at 0x1010, cti 010,111); irq after the 6th ack; next burst restarts at 0x1000.
- Insufficient data: burst_size=4, fifo_cnt=3 -> no cyc; raise fifo_cnt to 4 -> burst starts, cyc asserted within 2 cycles.
- Wait states/retry: ack every third cycle, rty pulsed mid-burst -> address and data held stable until ack; exactly one pop per ack; cti correct.
- Error: err on beat 2 of a 4-beat burst -> cyc drops next cycle; 1 pop total; bus_err=1; no new burst; enable 0->1 clears bus_err and restarts at start_adr.
- Reset mid-burst: rst_n low during beat 3 -> all outputs 0 asynchronously; after release with enable=1, the first burst starts at start_adr.
